// File: rtl/ble_pdu_deframer.sv
// BLE link-layer deframer: access-address hunt, dewhitening, LSB-first byte
// assembly, CRC-24 check and a small valid/ready output FIFO of {last, data}.
module ble_pdu_deframer #(
  parameter logic [31:0] ACC_ADDR   = 32'h6B7D9171,
  parameter logic [5:0]  CHANNEL    = 6'd37,
  parameter logic [23:0] CRC_INIT   = 24'h555555,
  parameter logic [23:0] CRC_POLY   = 24'h00065B,
  parameter int          MAX_LEN    = 37,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic       value,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       byte_last,
  output logic       pkt_done,
  output logic       crc_ok,
  output logic       len_err,
  output logic       overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {S_HUNT, S_HEADER, S_PAYLOAD, S_CRC} state_t;

  state_t      state;
  logic        upd_d;
  logic [31:0] aa;
  logic [6:0]  w;
  logic [23:0] crc;
  logic [7:0]  sh;
  logic [2:0]  bit_cnt;
  logic        hdr_byte;
  logic [7:0]  hdr0;
  logic [7:0]  len;
  logic [7:0]  pay_cnt;
  logic [4:0]  crc_cnt;
  logic        crc_acc;
  logic        push_req;
  logic [7:0]  push_data;
  logic        push_last;
  logic        hdr1_pend;
  logic [7:0]  hdr1_data;
  logic        hdr1_last;

  logic        strobe, d, crc_fb, crc_bit, aa_match, pay_last;
  logic [6:0]  w_next, w_seed;
  logic [23:0] crc_next;
  logic [7:0]  sh_next;

  // Whitening seed is the channel index bit-reversed above a constant 1.
  assign w_seed[0] = 1'b1;
  for (genvar gi = 1; gi < 7; gi++) begin : g_seed
    assign w_seed[gi] = CHANNEL[6-gi];
  end

  assign strobe   = update & ~upd_d;
  assign d        = value ^ w[6];
  assign w_next   = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
  assign crc_fb   = d ^ crc[23];
  assign crc_next = {crc[22:0], 1'b0} ^ (crc_fb ? CRC_POLY : 24'h000000);
  assign sh_next  = {d, sh[7:1]};
  assign crc_bit  = crc[5'd23 - crc_cnt];
  assign aa_match = (state == S_HUNT) && (aa == ACC_ADDR);
  assign pay_last = ((pay_cnt + 8'd1) == len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_HUNT;
      upd_d     <= 1'b0;
      aa        <= '0;
      w         <= '0;
      crc       <= '0;
      sh        <= '0;
      bit_cnt   <= '0;
      hdr_byte  <= 1'b0;
      hdr0      <= '0;
      len       <= '0;
      pay_cnt   <= '0;
      crc_cnt   <= '0;
      crc_acc   <= 1'b0;
      push_req  <= 1'b0;
      push_data <= '0;
      push_last <= 1'b0;
      hdr1_pend <= 1'b0;
      hdr1_data <= '0;
      hdr1_last <= 1'b0;
      pkt_done  <= 1'b0;
      crc_ok    <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      upd_d     <= update;
      pkt_done  <= 1'b0;
      len_err   <= 1'b0;
      push_req  <= 1'b0;
      hdr1_pend <= 1'b0;
      // Header byte 1 trails byte 0 by one cycle so both can use the single push port.
      if (hdr1_pend) begin
        push_req  <= 1'b1;
        push_data <= hdr1_data;
        push_last <= hdr1_last;
      end
      case (state)
        S_HUNT: begin
          if (aa_match) begin
            state    <= S_HEADER;
            w        <= w_seed;
            crc      <= CRC_INIT;
            aa       <= '0;
            bit_cnt  <= '0;
            hdr_byte <= 1'b0;
          end else if (strobe) begin
            aa <= {value, aa[31:1]};
          end
        end
        S_HEADER: begin
          if (strobe) begin
            w       <= w_next;
            crc     <= crc_next;
            sh      <= sh_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (!hdr_byte) begin
                hdr0     <= sh_next;
                hdr_byte <= 1'b1;
              end else begin
                hdr_byte <= 1'b0;
                len      <= sh_next;
                if (sh_next > MAX_LEN_B) begin
                  len_err <= 1'b1;
                  state   <= S_HUNT;
                end else begin
                  push_req  <= 1'b1;
                  push_data <= hdr0;
                  push_last <= 1'b0;
                  hdr1_pend <= 1'b1;
                  hdr1_data <= sh_next;
                  hdr1_last <= (sh_next == 8'd0);
                  pay_cnt   <= '0;
                  crc_cnt   <= '0;
                  crc_acc   <= 1'b1;
                  state     <= (sh_next == 8'd0) ? S_CRC : S_PAYLOAD;
                end
              end
            end
          end
        end
        S_PAYLOAD: begin
          if (strobe) begin
            w       <= w_next;
            crc     <= crc_next;
            sh      <= sh_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              push_req  <= 1'b1;
              push_data <= sh_next;
              push_last <= pay_last;
              pay_cnt   <= pay_cnt + 8'd1;
              if (pay_last) state <= S_CRC;
            end
          end
        end
        S_CRC: begin
          // CRC register is frozen here; received bits are compared MSB first.
          if (strobe) begin
            w       <= w_next;
            crc_cnt <= crc_cnt + 5'd1;
            crc_acc <= crc_acc & (d == crc_bit);
            if (crc_cnt == 5'd23) begin
              crc_ok   <= crc_acc & (d == crc_bit);
              pkt_done <= 1'b1;
              state    <= S_HUNT;
              aa       <= '0;
            end
          end
        end
        default: state <= S_HUNT;
      endcase
    end
  end

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, do_pop, do_push, drop;
  logic [8:0]    head;

  assign full       = (count == DEPTH_C);
  assign byte_valid = (count != '0);
  assign do_pop     = byte_valid & byte_ready;
  assign do_push    = push_req & (~full | do_pop);
  assign drop       = push_req & full & ~do_pop;
  assign head       = mem[rd_ptr];
  assign byte_data  = byte_valid ? head[7:0] : 8'h00;
  assign byte_last  = byte_valid & head[8];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_last, push_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
      else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
      if (aa_match)  overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end
endmodule
